// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter and its decoder.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index arithmetic wraps naturally at IDX_W bits, so 7 + 1 gives 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/decoder_3to8.sv
// Enable-gated binary-to-one-hot decoder; output is all-zero while en is low.
module decoder_3to8
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with hold-time limit: a grantee keeps the
// resource until it drops its request, or is preempted after MAX_HOLD cycles if others wait.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [7:0]       hold_cnt, hold_cnt_nxt;

    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             pick_found;
    logic [N_REQ-1:0] own_mask;
    logic             owner_req;
    logic             others_req;
    logic             timeout;

    // Rotating search: scanning from the far end lets the candidate closest to ptr win last.
    always_comb begin
        pick       = ptr;
        cand       = ptr;
        pick_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign own_mask   = N_REQ'(1) << idx_q;
    assign owner_req  = |(req & own_mask);
    assign others_req = |(req & ~own_mask);

    // A release in the same cycle as the limit wins, so timeout needs the owner still requesting.
    assign timeout = (state == GRANT) && owner_req && others_req && (hold_cnt == HOLD_LAST);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        idx_nxt      = idx_q;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = GRANT;
                    idx_nxt      = pick;
                    hold_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!owner_req || timeout) begin
                    state_nxt = IDLE;
                    ptr_nxt   = next_idx(idx_q);
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            idx_q    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            idx_q    <= idx_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_idx   = idx_q;
    assign preempt   = timeout;

    decoder_3to8 u_dec (
        .en  (gnt_valid),
        .idx (idx_q),
        .dec (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a cycle-level ownership model predicts outputs,
// a negedge monitor pops and compares them.
module tb_rr_arbiter_8;

    localparam int MH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       preempt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: who owns the resource (-1 = nobody), how many grant cycles so far, where the next search starts.
    int owner = -1;
    int held  = 0;
    int nxt   = 0;

    int   grant_log[$];
    int   preempt_seen = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic bit others_waiting(input logic [7:0] r);
        logic [7:0] m;
        m = r;
        m[owner] = 1'b0;
        return m != 8'h00;
    endfunction

    task automatic model_step(input logic [7:0] r);
        int f;
        if (owner < 0) begin
            f = first_from(r, nxt);
            if (f >= 0) begin
                owner = f;
                held  = 1;
            end
        end else if (!r[owner] || (held >= MH && others_waiting(r))) begin
            nxt   = (owner + 1) % 8;
            owner = -1;
        end else begin
            held++;
        end
    endtask

    function automatic exp_t predict(input logic [7:0] r);
        exp_t e;
        e.valid   = (owner >= 0);
        e.gnt     = 8'h00;
        e.idx     = 3'd0;
        e.preempt = 1'b0;
        if (owner >= 0) begin
            e.gnt     = 8'(1) << owner;
            e.idx     = 3'(owner);
            e.preempt = r[owner] && (held >= MH) && others_waiting(r);
        end
        return e;
    endfunction

    // One clock: the edge consumes the previous req, then the next req is applied and its outputs predicted.
    task automatic drive_cycle(input logic [7:0] r, input bit release3 = 1'b0);
        logic [7:0] r_eff;
        @(posedge clk);
        model_step(req);
        #1;
        r_eff = r;
        if (release3 && owner >= 0 && held == 3) r_eff[owner] = 1'b0;
        req = r_eff;
        sb.push_back(predict(r_eff));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req   = 8'h00;
        #1;
        check("rst_gnt", gnt, 8'h00);
        check("rst_gnt_valid", gnt_valid, 1'b0);
        check("rst_preempt", preempt, 1'b0);
        check("rst_gnt_idx", gnt_idx, 3'd0);
        sb.delete();
        grant_log.delete();
        owner        = -1;
        held         = 0;
        nxt          = 0;
        preempt_seen = 0;
        prev_valid   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
    endtask

    function automatic int log_at(input int i);
        return (grant_log.size() > i) ? grant_log[i] : -1;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("gnt", gnt, mon_e.gnt);
            check("gnt_valid", gnt_valid, mon_e.valid);
            check("preempt", preempt, mon_e.preempt);
            if (mon_e.valid) check("gnt_idx", gnt_idx, mon_e.idx);
            if (gnt_valid && !prev_valid) grant_log.push_back(int'(gnt_idx));
            prev_valid = gnt_valid;
            if (preempt) preempt_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;

        // Idle with no requests.
        do_reset();
        repeat (5) drive_cycle(8'h00);
        drain();
        check("idle_no_grants", grant_log.size(), 0);

        // Two requesters, release, then the next one in rotation.
        do_reset();
        repeat (3) drive_cycle(8'h24);
        repeat (4) drive_cycle(8'h20);
        drain();
        check("two_req_first", log_at(0), 2);
        check("two_req_second", log_at(1), 5);

        // Everyone requesting, each grantee holds three cycles: order must wrap 7 -> 0.
        do_reset();
        repeat (40) drive_cycle(8'hFF, 1'b1);
        drain();
        for (int i = 0; i < 9; i++) check($sformatf("fair_order_%0d", i), log_at(i), i % 8);

        // Timeout: idx 3 holds, idx 6 waits from cycle 2.
        do_reset();
        drive_cycle(8'h08);
        repeat (25) drive_cycle(8'h48);
        drain();
        check("timeout_pulses", preempt_seen, 1);
        check("timeout_first", log_at(0), 3);
        check("timeout_next", log_at(1), 6);

        // Lone requester never preempted.
        do_reset();
        repeat (41) drive_cycle(8'h02);
        drain();
        check("lone_pulses", preempt_seen, 0);
        check("lone_grants", grant_log.size(), 1);

        // Asynchronous reset in the middle of a grant, then a fresh search.
        do_reset();
        repeat (4) drive_cycle(8'h08);
        drain();
        check("mid_grant_valid", gnt_valid, 1'b1);
        do_reset();
        repeat (3) drive_cycle(8'h80);
        drain();
        check("post_rst_grant", log_at(0), 7);

        // Pointer must restart at 0: after idx 3 releases, reset, then 0 and 4 both request.
        do_reset();
        repeat (3) drive_cycle(8'h08);
        repeat (2) drive_cycle(8'h00);
        do_reset();
        repeat (3) drive_cycle(8'h11);
        drain();
        check("ptr_restart", log_at(0), 0);

        // Randomised traffic: mostly sticky requests with occasional bursts and resets.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int c = 0; c < 700; c++) begin
                if ($urandom_range(49) == 0) begin
                    r = 8'($urandom);
                end else begin
                    r = req;
                    for (int b = 0; b < 8; b++) begin
                        if ($urandom_range(7) == 0) r[b] = ~r[b];
                    end
                end
                drive_cycle(r);
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, max consecutive grant cycles before forced rotation when others wait; legal range 2..255.
REQ-002 Port: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  per-requester request; bit i held high while requester i wants/uses the shared resource.
REQ-005 Port: gnt  output  8  one-hot grant; all-zero when none.
REQ-006 Port: gnt_idx  output  3  binary index of current grantee; valid only when gnt_valid=1.
REQ-007 Port: gnt_valid  output  1  high while a grant is held.
REQ-008 Port: preempt  output  1  one-cycle pulse in the cycle a grant is revoked by timeout.

Function
REQ-009 FSM SHALL have two states, IDLE and GRANT; gnt_valid=1 exactly in GRANT.
REQ-010 IDLE: if req!=0, select first i with req[i]=1 searching ptr, ptr+1, ... mod 8; register gnt_idx=i, enter GRANT next edge (grant latency 1 cycle from sampled req).
REQ-011 IDLE with req=0: remain IDLE, gnt=0, ptr unchanged.
REQ-012 gnt SHALL equal one-hot decode of gnt_idx when gnt_valid=1, else 8'h00; never more than one bit set.
REQ-013 GRANT: if req[gnt_idx]=0 at an edge -> IDLE, ptr=gnt_idx+1 mod 8 (wraps 7->0); gnt drops same edge; one idle cycle before next grant.
REQ-014 Hold counter cleared on entering GRANT, increments each GRANT cycle, saturates at MAX_HOLD-1.
REQ-015 Counter==MAX_HOLD-1 and any other req bit set and req[gnt_idx]=1 -> preempt=1 that cycle, next edge -> IDLE, ptr=gnt_idx+1.
REQ-016 Counter saturated and no other requester -> grant continues indefinitely, no preempt.
REQ-017 Release and timeout in same cycle -> treated as release; preempt=0.
REQ-018 Requests arriving/dropping for non-granted indices during GRANT SHALL not affect grant.
REQ-019 Fairness: with all 8 requesting continuously, grants SHALL visit indices in strictly increasing order mod 8.

Reset
REQ-020 rst_n low asynchronously forces: state IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt=0, counter=0, preempt=0.
REQ-021 Reset asserted mid-GRANT drops gnt immediately, without waiting for clk.
REQ-022 First arbitration after rst_n deassertion starts search at index 0.

Structure
REQ-023 Shared package arb_pkg SHALL hold N_REQ=8, IDX_W=3, state encodings IDLE/GRANT.
REQ-024 Index-to-one-hot conversion SHALL instantiate existing sub-module decoder_3to8 (in=gnt_idx, out gated by gnt_valid).
REQ-025 Priority search, ptr, counter, FSM reside in rr_arbiter_8; no other sub-modules.

Verification
REQ-026 Reset then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, preempt=0 throughout.
REQ-027 After reset req=8'h24 -> next cycle gnt=8'h04, gnt_idx=2; drop req[2] -> gnt=0 one cycle, then gnt=8'h20, gnt_idx=5.
REQ-028 req=8'hFF held, each grantee releases after 3 cycles -> grant order 0,1,...,7,0; wrap 7->0 checked.
REQ-029 MAX_HOLD=16, req[3] held, req[6] raised cycle 2 -> preempt pulses 16th grant cycle of idx 3, then idle cycle, then gnt=8'h40.
REQ-030 req[1] only, held 40 cycles, MAX_HOLD=16 -> gnt=8'h02 continuous, preempt never asserted.
REQ-031 rst_n pulled low mid-GRANT between clock edges -> gnt=0 immediately; after release req=8'h80 -> gnt=8'h80, search from 0.
